forwarding_unit: RTL and testbench
==================================

# forwarding_unit

Tracks destination registers of in-flight instructions through EX, MEM and WB. Produces registered operand-forwarding selects for the instruction entering EX. Sits beside the load-use hazard detection unit in the 5-stage MIPS pipeline: it consumes that unit's stall and bubble decisions (`IDIF_write`, `ex_noop`) and resolves every remaining RAW hazard without stalling.

## Interface
Parameters:
- `BIT_WIDTH`, 32, datapath width; carried for uniformity, no datapath logic inside.
- `REG_ADDR_WIDTH`, 5, register address width.

Ports:
- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `id_rs` in REG_ADDR_WIDTH: source A of the instruction in ID.
- `id_rt` in REG_ADDR_WIDTH: source B of the instruction in ID.
- `id_dest` in REG_ADDR_WIDTH: destination of the instruction in ID, after rd/rt mux.
- `id_regWrite` in 1: the ID instruction writes the register file.
- `id_memRead` in 1: the ID instruction is a load.
- `IDIF_write` in 1: from the hazard unit; 0 means ID is held this cycle.
- `ex_noop` in 1: from the hazard unit; 1 means a bubble enters EX this edge.
- `fwd_a_sel` out 2: source-A select for the EX instruction. 00 = regfile, 01 = MEM-stage ALU result, 10 = WB-stage write data.
- `fwd_b_sel` out 2: same encoding, source B.
- `ex_memRead` out 1: the EX instruction is a load; feeds the hazard unit.
- `ex_rt` out REG_ADDR_WIDTH: destination of the EX instruction; feeds the hazard unit.
- `hazard_violation` out 1: sticky error flag.
- `wb_dest` out REG_ADDR_WIDTH: WB-stage destination.
- `wb_regWrite` out 1: WB-stage write enable.

## Operation
Internal shadow pipeline: {dest, regWrite, memRead} for each of EX, MEM and WB.

Every rising edge:
- **EX stage:**
  - If `ex_noop`=1: EX <= {0,0,0}, a bubble.
  - Otherwise: EX <= {id_dest, id_regWrite, id_memRead}.
- **MEM / WB:** MEM <= EX and WB <= MEM unconditionally. MEM and WB never stall.
- **Select for source s (s = `id_rs` for A, `id_rt` for B):**
  - If `ex_noop`=1: next select = 00.
  - Else if EX.regWrite, EX.dest≠0 and EX.dest==s: next select = 01.
  - Else if MEM.regWrite, MEM.dest≠0 and MEM.dest==s: next select = 10.
  - Else: next select = 00.
  - Priority is EX over MEM: the youngest producer wins.
  - Register 0 never forwards.
- **Selects are registered.** They are computed while the consumer sits in ID and are valid during the cycle the consumer sits in EX.
- **hazard_violation is set** (and held until reset) on any edge where any of the following holds:
  - `ex_noop`=0 and EX.memRead=1 and EX.dest≠0 and EX.dest equals `id_rs` or `id_rt`: a load-use hazard that was not stalled.
  - `IDIF_write`=0 while `ex_noop`=0: a held ID instruction was duplicated into EX.
- `ex_memRead` and `ex_rt` are EX.memRead and EX.dest.
- `wb_dest` and `wb_regWrite` are the WB-stage fields.

## Timing
- Reset (rst low, asynchronous): all stage fields 0, both selects 00, `hazard_violation` 0. First update occurs on the first rising edge after rst returns high.
- Producer-to-select latency: a producer in EX yields select 01 for a consumer one instruction behind it, and 10 for a consumer two behind.
- Stalled cycle (`IDIF_write`=0, `ex_noop`=1): a bubble enters EX and the selects are 00. The held ID instruction is re-evaluated on the next edge against the advanced EX/MEM contents. For a load followed by a use, that gives 10 from WB after the one-cycle stall.
- Reset asserted mid-stream: in-flight tracking is discarded immediately and no selects are stale after release.
- Simultaneous match on A and B: each select is evaluated independently.

## Configuration
- `FWD_WB_BYPASS_EN` defined:
  - Adds outputs `id_bypass_a` and `id_bypass_b` (1 bit each, combinational).
  - Each asserts when WB.regWrite, WB.dest≠0 and WB.dest equals `id_rs` / `id_rt`. This covers a register file that does not write-before-read.
  - A WB-stage producer three instructions ahead is then served in ID.
- Undefined: the ports are absent. The register file must write in the first half-cycle.

## Test plan
- Reset check: assert rst low mid-stream with EX.dest=5 -> selects 00, `hazard_violation` 0, `ex_rt` 0 immediately and without a clock edge.
- Back-to-back: `add r3` (id_dest=3, regWrite) then `sub` with id_rs=3, id_rt=3 -> `fwd_a_sel`=`fwd_b_sel`=01 in the sub's EX cycle.
- Distance two: `add r4`, `nop`, `or` with rt=4 -> `fwd_b_sel`=10 and `fwd_a_sel`=00. Then `add r4`, `add r4`, use r4 -> 01 (youngest wins).
- Load-use with stall: `lw r7`, then `add` rs=7, with `IDIF_write`=0 and `ex_noop`=1 for one cycle -> bubble in EX, then `fwd_a_sel`=10, violation stays 0.
- Missing stall: the same load-use sequence with `ex_noop` forced 0 -> `hazard_violation`=1, held until rst.
- Register zero: a writer to r0 followed by a reader with rs=0 -> select 00. With `FWD_WB_BYPASS_EN` defined, `id_bypass_a` also stays 0.

Source files
------------

// File: rtl/forwarding_unit.sv
// Operand-forwarding unit for a 5-stage MIPS pipeline: tracks in-flight destinations and registers EX-stage selects.
// Optional FWD_WB_BYPASS_EN adds combinational ID-stage bypass flags for a WB producer.
module forwarding_unit #(
  parameter int unsigned BIT_WIDTH      = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic [REG_ADDR_WIDTH-1:0] id_dest,
  input  logic                      id_regWrite,
  input  logic                      id_memRead,
  input  logic                      IDIF_write,
  input  logic                      ex_noop,
  output logic [1:0]                fwd_a_sel,
  output logic [1:0]                fwd_b_sel,
  output logic                      ex_memRead,
  output logic [REG_ADDR_WIDTH-1:0] ex_rt,
  output logic                      hazard_violation,
  output logic [REG_ADDR_WIDTH-1:0] wb_dest,
`ifdef FWD_WB_BYPASS_EN
  output logic                      id_bypass_a,
  output logic                      id_bypass_b,
`endif
  output logic                      wb_regWrite
);

  // Address width; the datapath width only documents the surrounding pipeline.
  localparam int unsigned AW = (BIT_WIDTH > 0) ? REG_ADDR_WIDTH : REG_ADDR_WIDTH;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  logic [AW-1:0] ex_dest_q, ex_dest_d;
  logic          ex_rw_q, ex_rw_d;
  logic          ex_mr_q, ex_mr_d;
  logic [AW-1:0] mem_dest_q, mem_dest_d;
  logic          mem_rw_q, mem_rw_d;
  logic [AW-1:0] wb_dest_q, wb_dest_d;
  logic          wb_rw_q, wb_rw_d;
  logic [1:0]    sel_a_q, sel_a_d;
  logic [1:0]    sel_b_q, sel_b_d;
  logic          viol_q, viol_d;
  logic          load_use_c;

  // Youngest producer wins; register zero never forwards.
  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src,
                                         input logic          ex_rw,
                                         input logic [AW-1:0] ex_dest,
                                         input logic          mem_rw,
                                         input logic [AW-1:0] mem_dest);
    logic [1:0] sel;
    sel = SEL_RF;
    if (ex_rw && (ex_dest != '0) && (ex_dest == src)) begin
      sel = SEL_MEM;
    end else if (mem_rw && (mem_dest != '0) && (mem_dest == src)) begin
      sel = SEL_WB;
    end
    return sel;
  endfunction

  always_comb begin
    ex_dest_d  = id_dest;
    ex_rw_d    = id_regWrite;
    ex_mr_d    = id_memRead;
    mem_dest_d = ex_dest_q;
    mem_rw_d   = ex_rw_q;
    wb_dest_d  = mem_dest_q;
    wb_rw_d    = mem_rw_q;
    sel_a_d    = SEL_RF;
    sel_b_d    = SEL_RF;
    viol_d     = viol_q;
    load_use_c = ex_mr_q && (ex_dest_q != '0) &&
                 ((ex_dest_q == id_rs) || (ex_dest_q == id_rt));

    if (ex_noop) begin
      ex_dest_d = '0;
      ex_rw_d   = 1'b0;
      ex_mr_d   = 1'b0;
    end else begin
      sel_a_d = fwd_sel(id_rs, ex_rw_q, ex_dest_q, mem_rw_q, mem_dest_q);
      sel_b_d = fwd_sel(id_rt, ex_rw_q, ex_dest_q, mem_rw_q, mem_dest_q);
      // Unstalled load-use, or a held ID instruction duplicated into EX.
      if (load_use_c || !IDIF_write) begin
        viol_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_dest_q  <= '0;
      ex_rw_q    <= 1'b0;
      ex_mr_q    <= 1'b0;
      mem_dest_q <= '0;
      mem_rw_q   <= 1'b0;
      wb_dest_q  <= '0;
      wb_rw_q    <= 1'b0;
      sel_a_q    <= SEL_RF;
      sel_b_q    <= SEL_RF;
      viol_q     <= 1'b0;
    end else begin
      ex_dest_q  <= ex_dest_d;
      ex_rw_q    <= ex_rw_d;
      ex_mr_q    <= ex_mr_d;
      mem_dest_q <= mem_dest_d;
      mem_rw_q   <= mem_rw_d;
      wb_dest_q  <= wb_dest_d;
      wb_rw_q    <= wb_rw_d;
      sel_a_q    <= sel_a_d;
      sel_b_q    <= sel_b_d;
      viol_q     <= viol_d;
    end
  end

  assign fwd_a_sel        = sel_a_q;
  assign fwd_b_sel        = sel_b_q;
  assign ex_memRead       = ex_mr_q;
  assign ex_rt            = ex_dest_q;
  assign hazard_violation = viol_q;
  assign wb_dest          = wb_dest_q;
  assign wb_regWrite      = wb_rw_q;

`ifdef FWD_WB_BYPASS_EN
  // Serves a WB producer in ID when the register file reads before it writes.
  assign id_bypass_a = wb_rw_q && (wb_dest_q != '0) && (wb_dest_q == id_rs);
  assign id_bypass_b = wb_rw_q && (wb_dest_q != '0) && (wb_dest_q == id_rt);
`endif

endmodule

// File: tb/tb_forwarding_unit.sv
// Scoreboard bench for forwarding_unit: instruction-history reference model, queue of expectations, negedge monitor.
module tb_forwarding_unit;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs, id_rt, id_dest;
  logic          id_regWrite, id_memRead, IDIF_write, ex_noop;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          ex_memRead, hazard_violation, wb_regWrite;
  logic [AW-1:0] ex_rt, wb_dest;
`ifdef FWD_WB_BYPASS_EN
  logic          id_bypass_a, id_bypass_b;
`endif

  forwarding_unit #(.BIT_WIDTH(32), .REG_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
    .id_regWrite(id_regWrite), .id_memRead(id_memRead),
    .IDIF_write(IDIF_write), .ex_noop(ex_noop),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .ex_memRead(ex_memRead), .ex_rt(ex_rt),
    .hazard_violation(hazard_violation), .wb_dest(wb_dest),
`ifdef FWD_WB_BYPASS_EN
    .id_bypass_a(id_bypass_a), .id_bypass_b(id_bypass_b),
`endif
    .wb_regWrite(wb_regWrite)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] dest;
    bit            rw;
    bit            mr;
  } instr_t;

  typedef struct {
    int            cyc;
    bit            kind;   // 0: registered outputs after an edge, 1: ID bypass flags
    logic [1:0]    a, b;
    bit            exmr;
    logic [AW-1:0] exrt;
    logic [AW-1:0] wbd;
    bit            wbrw;
    bit            viol;
    bit            ba, bb;
  } exp_t;

  int     errors = 0;
  int     checks = 0;
  int     cyc_cnt = 0;
  exp_t   sb[$];
  instr_t hist[$];   // issue-ordered history: [0]=WB, [1]=MEM, [2]=EX
  bit     m_viol;

  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_cnt, act, exp);
    end
  endtask

  function automatic logic [1:0] model_fwd(input logic [AW-1:0] src);
    // scan the two youngest instructions, youngest first
    for (int d = 0; d < 2; d++) begin
      instr_t p = hist[2 - d];
      if (p.rw && p.dest != 0 && p.dest == src) return 2'(d + 1);
    end
    return 2'd0;
  endfunction

  function automatic bit model_byp(input logic [AW-1:0] src);
    return hist[0].rw && hist[0].dest != 0 && hist[0].dest == src;
  endfunction

  task automatic model_reset();
    instr_t bub;
    bub = '{dest: '0, rw: 1'b0, mr: 1'b0};
    hist.delete();
    repeat (3) hist.push_back(bub);
    m_viol = 1'b0;
  endtask

  // Drive one ID-stage instruction, record its expectations, advance one edge.
  task automatic step(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                      input logic [AW-1:0] dest, input bit rw, input bit mr,
                      input bit idw, input bit noop);
    exp_t   e;
    instr_t ex, ins;
    id_rs = rs; id_rt = rt; id_dest = dest;
    id_regWrite = rw; id_memRead = mr; IDIF_write = idw; ex_noop = noop;
`ifdef FWD_WB_BYPASS_EN
    e = '{default: '0};
    e.kind = 1'b1; e.cyc = cyc_cnt;
    e.ba = model_byp(rs); e.bb = model_byp(rt);
    sb.push_back(e);
`endif
    e = '{default: '0};
    e.kind = 1'b0;
    e.cyc  = cyc_cnt + 1;
    e.a    = noop ? 2'd0 : model_fwd(rs);
    e.b    = noop ? 2'd0 : model_fwd(rt);
    ex = hist[2];
    if (!noop && ex.mr && ex.dest != 0 && (ex.dest == rs || ex.dest == rt)) m_viol = 1'b1;
    if (!noop && !idw) m_viol = 1'b1;
    ins = noop ? '{dest: '0, rw: 1'b0, mr: 1'b0} : '{dest: dest, rw: rw, mr: mr};
    hist.push_back(ins);
    void'(hist.pop_front());
    e.exmr = hist[2].mr;
    e.exrt = hist[2].dest;
    e.wbd  = hist[0].dest;
    e.wbrw = hist[0].rw;
    e.viol = m_viol;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Plain instruction shorthand: no stall, no bubble.
  task automatic op(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                    input logic [AW-1:0] dest, input bit rw, input bit mr);
    step(rs, rt, dest, rw, mr, 1'b1, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_fwd_a"}, 32'(fwd_a_sel), 32'd0);
    chk({tag, "_fwd_b"}, 32'(fwd_b_sel), 32'd0);
    chk({tag, "_viol"},  32'(hazard_violation), 32'd0);
    chk({tag, "_ex_rt"}, 32'(ex_rt), 32'd0);
    chk({tag, "_ex_mr"}, 32'(ex_memRead), 32'd0);
    chk({tag, "_wb_d"},  32'(wb_dest), 32'd0);
    chk({tag, "_wb_rw"}, 32'(wb_regWrite), 32'd0);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check_reset_values(tag);
    sb.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  // Monitor: pops every expectation due this cycle and compares.
  always @(negedge clk) begin
    if (rst) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc < cyc_cnt) begin
          chk("stale_expectation", 32'(e.cyc), 32'(cyc_cnt));
        end else if (e.kind == 1'b0) begin
          chk("fwd_a_sel",        32'(fwd_a_sel),        32'(e.a));
          chk("fwd_b_sel",        32'(fwd_b_sel),        32'(e.b));
          chk("ex_memRead",       32'(ex_memRead),       32'(e.exmr));
          chk("ex_rt",            32'(ex_rt),            32'(e.exrt));
          chk("wb_dest",          32'(wb_dest),          32'(e.wbd));
          chk("wb_regWrite",      32'(wb_regWrite),      32'(e.wbrw));
          chk("hazard_violation", 32'(hazard_violation), 32'(e.viol));
        end else begin
`ifdef FWD_WB_BYPASS_EN
          chk("id_bypass_a", 32'(id_bypass_a), 32'(e.ba));
          chk("id_bypass_b", 32'(id_bypass_b), 32'(e.bb));
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    id_rs = '0; id_rt = '0; id_dest = '0;
    id_regWrite = 1'b0; id_memRead = 1'b0; IDIF_write = 1'b1; ex_noop = 1'b0;
    model_reset();
    #1 check_reset_values("por");
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Mid-stream reset with EX.dest=5, live select and a set violation flag.
    op(0, 0, 5, 1, 0);
    op(5, 0, 5, 1, 0);
    step(5, 0, 5, 1, 0, 1'b0, 1'b0);
    do_reset("midrst");

    // Back-to-back: add r3; sub r3,r3 -> 01/01.
    op(1, 2, 3, 1, 0);
    op(3, 3, 8, 1, 0);
    op(0, 0, 0, 0, 0);

    // Distance two, then youngest-wins.
    op(1, 2, 4, 1, 0);
    op(0, 0, 0, 0, 0);
    op(9, 4, 10, 1, 0);
    op(1, 2, 4, 1, 0);
    op(1, 2, 4, 1, 0);
    op(4, 0, 11, 1, 0);

    // Load-use with a one-cycle stall -> 10 from WB, no violation.
    op(0, 0, 7, 1, 1);
    step(7, 0, 12, 1, 0, 1'b0, 1'b1);
    op(7, 0, 12, 1, 0);
    op(0, 0, 0, 0, 0);

    // Register zero never forwards.
    op(1, 2, 0, 1, 0);
    op(0, 0, 13, 1, 0);
    op(0, 0, 14, 1, 0);
    op(0, 0, 15, 1, 0);

    // Missing stall: violation sets and holds until reset.
    op(0, 0, 7, 1, 1);
    op(7, 0, 12, 1, 0);
    repeat (4) op(1, 2, 3, 1, 0);
    do_reset("viol_clr");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] rs, rt, dest;
      bit rw, mr, noop, idw;
      rs   = AW'($urandom_range(0, 7));
      rt   = AW'($urandom_range(0, 7));
      dest = AW'($urandom_range(0, 7));
      rw   = ($urandom_range(0, 3) != 0);
      mr   = rw && ($urandom_range(0, 3) == 0);
      noop = ($urandom_range(0, 7) == 0);
      idw  = noop ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 29) != 0);
      step(rs, rt, dest, rw, mr, idw, noop);
      if (i % 60 == 59) do_reset("rnd_rst");
    end

    repeat (2) @(posedge clk);
    #1 chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
